// File: rtl/dp_score_serializer.sv
// dp_score_serializer: frame-rate capture of the correlation sum, threshold detect, and framed byte streaming (optional DP_SER_CHECKSUM_EN adds a trailing XOR byte)
module dp_score_serializer #(
  parameter int                SUM_W     = 22,
  parameter int                FRAME_LEN = 256,
  parameter logic [SUM_W-1:0]  THRESH    = 22'd4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SUM_W-1:0] sum_in,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             detect,
  output logic             busy
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_B0   = 3'd2;
  localparam logic [2:0] S_B1   = 3'd3;
  localparam logic [2:0] S_B2   = 3'd4;
`ifdef DP_SER_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd5;
  localparam logic [2:0] S_LAST = S_CHK;
`else
  localparam logic [2:0] S_LAST = S_B2;
`endif
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             detect_q, detect_d;
  logic             ovf_q, ovf_d;
  logic             hovf_q, hovf_d;
  logic [23:0]      sum_x;
  logic [7:0]       data_byte;
  logic             tick, xfer, last, accept, reject;
  assign byte_out   = byte_out_q;
  assign byte_valid = state_q != S_IDLE;
  assign busy       = state_q != S_IDLE;
  assign detect     = detect_q;
  assign sum_x      = 24'(sum_q);
  // Byte loaded on entry to each data state; the checksum covers the header as it was sent
  always_comb begin
`ifdef DP_SER_CHECKSUM_EN
    data_byte = state_d == S_B0  ? sum_x[7:0] :
                state_d == S_B1  ? sum_x[15:8] :
                state_d == S_B2  ? sum_x[23:16] :
                state_d == S_CHK ? ({4'hA, detect_q, hovf_q, 2'b00} ^ sum_x[7:0] ^ sum_x[15:8] ^ sum_x[23:16]) :
                8'h00;
`else
    data_byte = state_d == S_B0 ? sum_x[7:0] :
                state_d == S_B1 ? sum_x[15:8] :
                state_d == S_B2 ? sum_x[23:16] :
                8'h00;
`endif
  end
  // Frame tick, capture acceptance, overrun bookkeeping and FSM advance
  always_comb begin
    xfer      = byte_valid & byte_ready;
    tick      = cnt_q == CW'(FRAME_LEN - 1);
    last      = state_q == S_LAST;
    accept    = tick & ((state_q == S_IDLE) | (last & xfer));
    reject    = tick & ~accept;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    sum_d     = accept ? sum_in : sum_q;
    detect_d  = accept ? (sum_in >= THRESH) : detect_q;
    hovf_d    = accept ? ovf_q : hovf_q;
    // Only an overrun already reported in the outgoing header is cleared; a new one always wins
    ovf_d     = reject | (ovf_q & ~((state_q == S_HDR) & xfer & hovf_q));
    state_d   = accept ? S_HDR : !xfer ? state_q : last ? S_IDLE : state_q + 3'd1;
    byte_out_d = accept ? {4'hA, sum_in >= THRESH, ovf_q, 2'b00} : !xfer ? byte_out_q : data_byte;
  end
  // State registers with asynchronous reset discarding any partial packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      sum_q      <= '0;
      byte_out_q <= '0;
      detect_q   <= 1'b0;
      ovf_q      <= 1'b0;
      hovf_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      sum_q      <= sum_d;
      byte_out_q <= byte_out_d;
      detect_q   <= detect_d;
      ovf_q      <= ovf_d;
      hovf_q     <= hovf_d;
    end
  end
endmodule

// File: doc/dp_score_serializer.md
# dp_score_serializer

Downstream readout stage for the constellation-density correlator. Once per frame it samples the 22-bit correlation sum produced by the two MAC stages. It thresholds the sample and streams it out as a framed byte sequence over an 8-bit valid/ready interface. This lets an off-chip host read the full-width result, not just the low 16 bits.

## Interface
Parameters:
- `SUM_W`, 22: width of `sum_in`. Legal range is 17..24; the upper data byte is zero-padded.
- `FRAME_LEN`, 256: cycles between captures. Must be at least 8.
- `THRESH`, 22'd4096: unsigned detect threshold.

Ports:
- `clk`, in, 1: the single clock; all state is updated on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `sum_in`, in, SUM_W: unsigned correlation sum from the MAC stage. Sampled only on a frame tick.
- `byte_out`, out, 8: the current byte of the packet.
- `byte_valid`, out, 1: `byte_out` holds a valid byte.
- `byte_ready`, in, 1: the consumer accepts the byte. A transfer occurs on any edge where `byte_valid && byte_ready`.
- `detect`, out, 1: registered result of `sum >= THRESH` for the most recent accepted capture.
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- **Frame counter:** free-running, counts 0..FRAME_LEN-1 and wraps. A tick is raised when the count equals FRAME_LEN-1.
- **FSM states:** IDLE, HDR, B0, B1, B2 (and CHK when the checksum option is enabled).
- **Tick acceptance:** a tick is accepted if either:
  - the FSM is in IDLE, or
  - the FSM is in its last state and that byte transfers on the same edge.
- **On an accepted tick:**
  - `sum_in` is latched into the shadow register.
  - `detect` is updated to `sum_in >= THRESH`.
  - The FSM moves to HDR.
- **On a rejected tick (FSM busy):** the sample is dropped, and the sticky overrun flag `ovf` is set.
- **Packet format:**
  - Header byte: `{4'hA, detect, ovf, 2'b00}`.
  - B0: sum[7:0].
  - B1: sum[15:8].
  - B2: sum[SUM_W-1:16], zero-extended to 8 bits.
- **Overrun flag:**
  - `ovf` is cleared on the edge where the header transfers.
  - If a rejected tick occurs on that same edge, set wins and `ovf` stays 1.
- **State advance:** each state advances only on a transfer. From the last state, the FSM goes to IDLE, or to HDR if a tick is accepted on that edge.
- **Output stability:** while `byte_valid` is high and `byte_ready` is low, `byte_out` holds stable. `byte_valid` never drops without a transfer.
- **Shadow register:** does not change while the FSM is busy.

## Timing
- **Reset values:** `byte_out`=0, `byte_valid`=0, `detect`=0, `busy`=0, `ovf`=0, counter=0, state IDLE.
- **Reset assertion:** takes effect immediately, including mid-packet. The partial packet is discarded.
- **First tick:** occurs on the FRAME_LEN-th rising edge after `rst_n` is released.
- **Latency:** the header is valid in the cycle directly after the accepting edge.
- **Packet length:** with `byte_ready` held high, a packet occupies 4 consecutive cycles (5 with the checksum option).
- **Comparison:** unsigned. `sum == THRESH` gives `detect`=1.

## Configuration
- **Macro:** `DP_SER_CHECKSUM_EN`.
- **When defined:** the FSM gains a CHK state after B2. CHK emits the XOR of the header, B0, B1 and B2, and CHK becomes the last state.
- **When undefined:** B2 is the last state, and no checksum logic exists.

## Test plan
Bench parameters: FRAME_LEN=16, THRESH=1000, SUM_W=22.

1. **Reset values:** hold `rst_n` low with random `sum_in` -> all outputs read 0. After release, `byte_valid` stays 0 for 16 edges.
2. **Basic packet:** `sum_in`=0x12345, `byte_ready`=1 -> bytes 0xA8, 0x45, 0x23, 0x01 on consecutive cycles, `detect`=1. With `DP_SER_CHECKSUM_EN`, a fifth byte 0xCF follows.
3. **Threshold boundary:** `sum_in`=999 -> 0xA0, 0xE7, 0x03, 0x00 with `detect`=0. `sum_in`=1000 -> header 0xA8.
4. **Overrun:** hold `byte_ready`=0 for 40 cycles -> the tick at edge 32 is dropped and the header stays 0xA8. After release, the packet completes. The next accepted packet's header is 0xAC, and the one after that is 0xA8.
5. **Tick on final transfer:** stall `byte_ready` so that B2 transfers on the tick edge -> the header is valid on the next cycle, with no `ovf` and no idle gap.
6. **Reset mid-packet:** assert `rst_n` low while B1 is pending -> `byte_valid`=0 immediately. After release, the first header appears 16 edges later with `ovf`=0.
